// File: rtl/lsu_mmio_bridge_if.sv
// Core-side request/response and target-side bus of the load/store MMIO bridge.
interface lsu_mmio_bridge_if #(
  parameter int NUM_REGIONS  = 2,
  parameter int REGION_SHIFT = 16
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      resp_valid;
  logic [31:0]               resp_rdata;
  logic [1:0]                resp_err;
  logic [NUM_REGIONS-1:0]    dev_sel;
  logic                      dev_we;
  logic [REGION_SHIFT-1:0]   dev_addr;
  logic [3:0]                dev_be;
  logic [31:0]               dev_wdata;
  logic [NUM_REGIONS*32-1:0] dev_rdata;
  logic [NUM_REGIONS-1:0]    dev_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  dev_rdata, dev_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dev_sel, dev_we, dev_addr, dev_be, dev_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output dev_rdata, dev_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dev_sel, dev_we, dev_addr, dev_be, dev_wdata
  );
endinterface

// File: rtl/lsu_mmio_bridge.sv
// Load/store bridge: region decode, lane steering, extension, alignment and timeout.
//   state    | meaning
//   S_IDLE   | ready for a request; checks run on accept
//   S_ACCESS | target selected, waiting for its ack or the timeout
//   S_RESP   | one-cycle response strobe, target bus idle
module lsu_mmio_bridge #(
  parameter int NUM_REGIONS    = 2,
  parameter int REGION_SHIFT   = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic clk,
  input logic rst,
  lsu_mmio_bridge_if.slave bus
);
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] idx_q;
  logic          we_q, uns_q;
  logic [1:0]    size_q, lane_q;

  logic                    resp_valid_q;
  logic [31:0]             resp_rdata_q, rdata_d;
  logic [1:0]              resp_err_q, err_d;
  logic [NUM_REGIONS-1:0]  dev_sel_q;
  logic                    dev_we_q;
  logic [REGION_SHIFT-1:0] dev_addr_q;
  logic [3:0]              dev_be_q, be_new;
  logic [31:0]             dev_wdata_q, wdata_new;

  logic [31:0] region_full, sel_rdata, lane_data, load_data;
  logic        bad_req, misaligned, ack, timeout_hit;

  assign region_full = bus.req_addr >> REGION_SHIFT;
  assign bad_req     = (bus.req_size == 2'b11) || (region_full >= 32'(NUM_REGIONS));
  assign misaligned  = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign sel_rdata   = bus.dev_rdata[32*int'(idx_q) +: 32];
  assign ack         = bus.dev_ack[idx_q];
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign lane_data   = sel_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_data = lane_data;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_data = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
      default: load_data = lane_data;
    endcase
  end

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_new    = 4'b0001 << bus.req_addr[1:0];
        wdata_new = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << bus.req_addr[1:0];
        wdata_new = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 2'b00;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          if (bad_req) begin
            state_d = S_RESP;
            err_d   = 2'b10;
          end else if (misaligned) begin
            state_d = S_RESP;
            err_d   = 2'b01;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final timeout cycle still counts as success.
        if (ack) begin
          state_d = S_RESP;
          rdata_d = we_q ? 32'h0 : load_data;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 2'b11;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 2'b00;
      dev_sel_q    <= '0;
      dev_we_q     <= 1'b0;
      dev_addr_q   <= '0;
      dev_be_q     <= 4'b0000;
      dev_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= (state_d == S_RESP);
      if (state_q == S_IDLE && bus.req_valid) begin
        idx_q  <= region_full[RW-1:0];
        we_q   <= bus.req_we;
        uns_q  <= bus.req_unsigned;
        size_q <= bus.req_size;
        lane_q <= bus.req_addr[1:0];
      end
      if (state_q == S_IDLE && state_d == S_ACCESS) begin
        dev_sel_q   <= NUM_REGIONS'(1) << region_full[RW-1:0];
        dev_we_q    <= bus.req_we;
        dev_addr_q  <= bus.req_addr[REGION_SHIFT-1:0] & ~REGION_SHIFT'(3);
        dev_be_q    <= be_new;
        dev_wdata_q <= wdata_new;
      end else if (state_d != S_ACCESS) begin
        dev_sel_q   <= '0;
        dev_we_q    <= 1'b0;
        dev_addr_q  <= '0;
        dev_be_q    <= 4'b0000;
        dev_wdata_q <= '0;
      end
      if (state_q != S_RESP && state_d == S_RESP) begin
        resp_err_q   <= err_d;
        resp_rdata_q <= rdata_d;
      end else if (state_q == S_RESP) begin
        resp_err_q   <= 2'b00;
        resp_rdata_q <= '0;
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.dev_sel    = dev_sel_q;
  assign bus.dev_we     = dev_we_q;
  assign bus.dev_addr   = dev_addr_q;
  assign bus.dev_be     = dev_be_q;
  assign bus.dev_wdata  = dev_wdata_q;
endmodule
